alu_writeback: RTL and testbench

Writeback stage directly downstream of the Rapids ALU. It captures each ALU result pair (Y1, Y2) together with its destination register tags into a small FIFO. It then drains each pair through the register file's single write port, one 32-bit word per cycle. It also answers a combinational hazard query, so that the issue stage can stall reads of registers that still have writes pending.

---
 rtl/alu_writeback.sv | 138 +++++++++++++
 tb/tb_alu_writeback.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: buffers result pairs and drains them one word
// per cycle into the register file's single write port, with a pending-write hazard query.
module alu_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_y1,
  input  logic [31:0]   in_y2,
  input  logic          in_we1,
  input  logic          in_we2,
  input  logic [AW-1:0] in_dst1,
  input  logic [AW-1:0] in_dst2,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [31:0]   rf_data,
  input  logic [AW-1:0] hz_addr,
  output logic          hz_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {H1, H2} ph_e;

  logic [31:0]   y1_q [DEPTH];
  logic [31:0]   y2_q [DEPTH];
  logic [AW-1:0] d1_q [DEPTH];
  logic [AW-1:0] d2_q [DEPTH];
  logic [DEPTH-1:0] p1_q, p2_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  ph_e           ph_q, ph_d;

  logic          rf_we_q;
  logic [AW-1:0] rf_addr_q;
  logic [31:0]   rf_data_q;

  logic          push, pop, clr1, iss;
  logic [AW-1:0] iss_addr;
  logic [31:0]   iss_data;
  logic [PW-1:0] off;
  logic          hz;

  // A full FIFO refuses a push even when the head pops in the same cycle.
  assign in_ready = !rst && (cnt_q < (PW+1)'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    pop      = 1'b0;
    clr1     = 1'b0;
    iss      = 1'b0;
    iss_addr = d1_q[rd_q];
    iss_data = y1_q[rd_q];
    ph_d     = ph_q;
    if (cnt_q != '0) begin
      if (ph_q == H1 && p1_q[rd_q]) begin
        iss  = 1'b1;
        clr1 = 1'b1;
        ph_d = H2;
      end else begin
        // Y1 absent or already written: finish the entry this cycle.
        pop  = 1'b1;
        ph_d = H1;
        if (p2_q[rd_q]) begin
          iss      = 1'b1;
          iss_addr = d2_q[rd_q];
          iss_data = y2_q[rd_q];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ph_q      <= H1;
      p1_q      <= '0;
      p2_q      <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      if (push) begin
        wr_q       <= wr_q + PW'(1);
        p1_q[wr_q] <= in_we1 && (in_dst1 != '0);
        p2_q[wr_q] <= in_we2 && (in_dst2 != '0);
      end
      if (clr1) p1_q[rd_q] <= 1'b0;
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      ph_q    <= ph_d;
      rf_we_q <= iss;
      if (iss) begin
        rf_addr_q <= iss_addr;
        rf_data_q <= iss_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      y1_q[wr_q] <= in_y1;
      y2_q[wr_q] <= in_y2;
      d1_q[wr_q] <= in_dst1;
      d2_q[wr_q] <= in_dst2;
    end
  end

  // The rf_* register still counts as pending until the register file commits it.
  always_comb begin
    hz  = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if ({1'b0, off} < cnt_q) begin
        if (p1_q[i] && d1_q[i] == hz_addr) hz = 1'b1;
        if (p2_q[i] && d2_q[i] == hz_addr) hz = 1'b1;
      end
    end
    if (rf_we_q && rf_addr_q == hz_addr) hz = 1'b1;
    if (hz_addr == '0) hz = 1'b0;
  end

  assign hz_pending = hz;
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: reset, drain ordering, skipped halves,
// same destination, hazard query, backpressure with wrap, and reset mid-drain.
module tb_alu_writeback;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y1, in_y2;
  logic        in_we1, in_we2;
  logic [4:0]  in_dst1, in_dst2;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  hz_addr;
  logic        hz_pending;

  int checks = 0;
  int errors = 0;

  alu_writeback #(.DEPTH(4), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y1(in_y1), .in_y2(in_y2),
    .in_we1(in_we1), .in_we2(in_we2),
    .in_dst1(in_dst1), .in_dst2(in_dst2),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .hz_addr(hz_addr), .hz_pending(hz_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] y1, input logic [31:0] y2,
                       input logic w1, input logic w2, input logic [4:0] d1, input logic [4:0] d2);
    in_valid = v; in_y1 = y1; in_y2 = y2;
    in_we1 = w1; in_we2 = w2; in_dst1 = d1; in_dst2 = d2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    hz_addr = 5'd3;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
    checks++; if (rf_data !== 32'h0) begin errors++; $display("FAIL reset_rf_data: got %h want 0", rf_data); end
    checks++; if (hz_pending !== 1'b0) begin errors++; $display("FAIL reset_hz: got %b want 0", hz_pending); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_pair;
    drive(1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b1, 5'd3, 5'd4);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_e1_we: got %b want 0", rf_we); end
    @(negedge clk);
    checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd3, 32'h11111111}) begin
      errors++; $display("FAIL single_y1: got we=%b addr=%0d data=%h want we=1 addr=3 data=11111111", rf_we, rf_addr, rf_data); end
    @(negedge clk);
    checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd4, 32'h22222222}) begin
      errors++; $display("FAIL single_y2: got we=%b addr=%0d data=%h want we=1 addr=4 data=22222222", rf_we, rf_addr, rf_data); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_idle: got we=%b want 0", rf_we); end
  endtask

  task automatic test_skip_halves;
    drive(1'b1, 32'h66666666, 32'h77777777, 1'b0, 1'b1, 5'd6, 5'd7);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL skip_accept_we: got %b want 0", rf_we); end
    @(negedge clk);
    checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd7, 32'h77777777}) begin
      errors++; $display("FAIL skip_y2: got we=%b addr=%0d data=%h want we=1 addr=7 data=77777777", rf_we, rf_addr, rf_data); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL skip_one_word: got we=%b want 0", rf_we); end
    // r0-only entry followed immediately by a one-word pair to r2
    drive(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b1, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 32'h00000022, 32'h0, 1'b1, 1'b0, 5'd2, 5'd0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_accept_we: got %b want 0", rf_we); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_pop_we: got %b want 0", rf_we); end
    @(negedge clk);
    checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd2, 32'h00000022}) begin
      errors++; $display("FAIL r0_next_pair: got we=%b addr=%0d data=%h want we=1 addr=2 data=22", rf_we, rf_addr, rf_data); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_idle: got we=%b want 0", rf_we); end
  endtask

  task automatic test_same_dst;
    drive(1'b1, 32'hA, 32'hB, 1'b1, 1'b1, 5'd5, 5'd5);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd5, 32'hA}) begin
      errors++; $display("FAIL same_first: got we=%b addr=%0d data=%h want we=1 addr=5 data=a", rf_we, rf_addr, rf_data); end
    @(negedge clk);
    checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd5, 32'hB}) begin
      errors++; $display("FAIL same_second: got we=%b addr=%0d data=%h want we=1 addr=5 data=b", rf_we, rf_addr, rf_data); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL same_idle: got we=%b want 0", rf_we); end
  endtask

  task automatic test_hazard;
    drive(1'b1, 32'h88, 32'h99, 1'b1, 1'b1, 5'd8, 5'd9);
    hz_addr = 5'd9; #1;
    checks++; if (hz_pending !== 1'b0) begin errors++; $display("FAIL hz_incoming: got %b want 0", hz_pending); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    hz_addr = 5'd9; #1;
    checks++; if (hz_pending !== 1'b1) begin errors++; $display("FAIL hz_buffered9: got %b want 1", hz_pending); end
    hz_addr = 5'd8; #1;
    checks++; if (hz_pending !== 1'b1) begin errors++; $display("FAIL hz_buffered8: got %b want 1", hz_pending); end
    hz_addr = 5'd0; #1;
    checks++; if (hz_pending !== 1'b0) begin errors++; $display("FAIL hz_r0: got %b want 0", hz_pending); end
    hz_addr = 5'd10; #1;
    checks++; if (hz_pending !== 1'b0) begin errors++; $display("FAIL hz_other: got %b want 0", hz_pending); end
    hz_addr = 5'd9;
    @(negedge clk);
    checks++; if (hz_pending !== 1'b1 || rf_addr !== 5'd8) begin
      errors++; $display("FAIL hz_after_y1: got hz=%b addr=%0d want hz=1 addr=8", hz_pending, rf_addr); end
    @(negedge clk);
    checks++; if (hz_pending !== 1'b1 || rf_we !== 1'b1 || rf_addr !== 5'd9) begin
      errors++; $display("FAIL hz_in_flight: got hz=%b we=%b addr=%0d want hz=1 we=1 addr=9", hz_pending, rf_we, rf_addr); end
    @(negedge clk);
    checks++; if (hz_pending !== 1'b0) begin errors++; $display("FAIL hz_committed: got %b want 0", hz_pending); end
    hz_addr = 5'd8; #1;
    checks++; if (hz_pending !== 1'b0) begin errors++; $display("FAIL hz_committed8: got %b want 0", hz_pending); end
  endtask

  task automatic test_back_to_back;
    logic [36:0] exp_q[$];
    logic [36:0] e;
    int sent = 0;
    int cyc = 0;
    int sent_at_drop = -1;
    while ((sent < 12 || exp_q.size() != 0) && cyc < 300) begin
      if (cyc > 0 && rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_write: got addr=%0d data=%h want no write", rf_addr, rf_data);
        end else begin
          e = exp_q.pop_front();
          if ({rf_addr, rf_data} !== e) begin
            errors++; $display("FAIL b2b_order: got addr=%0d data=%h want addr=%0d data=%h", rf_addr, rf_data, e[36:32], e[31:0]);
          end
        end
      end
      if (sent < 12) begin
        drive(1'b1, 32'h10000000 + sent, 32'h20000000 + sent, 1'b1, 1'b1, 5'(sent + 1), 5'(sent + 16));
        if (in_ready === 1'b1) begin
          exp_q.push_back({5'(sent + 1), 32'h10000000 + sent});
          exp_q.push_back({5'(sent + 16), 32'h20000000 + sent});
          sent++;
        end else if (sent_at_drop < 0) begin
          sent_at_drop = sent;
        end
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
      end
      @(negedge clk);
      cyc++;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (cyc >= 300) begin errors++; $display("FAIL b2b_timeout: got %0d pending words want 0", exp_q.size()); end
    checks++; if (sent_at_drop != 6) begin errors++; $display("FAIL b2b_backpressure: got ready drop after %0d pairs want 6", sent_at_drop); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_idle: got we=%b want 0", rf_we); end
  endtask

  task automatic test_reset_mid_drain;
    drive(1'b1, 32'h31, 32'h32, 1'b1, 1'b1, 5'd11, 5'd12);
    @(negedge clk);
    drive(1'b1, 32'h41, 32'h42, 1'b1, 1'b1, 5'd13, 5'd14);
    @(negedge clk);
    drive(1'b1, 32'h51, 32'h52, 1'b1, 1'b1, 5'd15, 5'd16);
    checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd11, 32'h31}) begin
      errors++; $display("FAIL mid_first_write: got we=%b addr=%0d data=%h want we=1 addr=11 data=31", rf_we, rf_addr, rf_data); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || rf_data !== 32'h0) begin
      errors++; $display("FAIL mid_reset_rf: got we=%b data=%h want we=0 data=0", rf_we, rf_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", in_ready); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b want 1", in_ready); end
    hz_addr = 5'd14; #1;
    checks++; if (hz_pending !== 1'b0) begin errors++; $display("FAIL mid_hz: got %b want 0", hz_pending); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_no_write: cycle %0d got we=%b want 0", i, rf_we); end
    end
  endtask

  initial begin
    rst = 1'b1;
    hz_addr = 5'd0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    test_reset;
    test_single_pair;
    test_skip_halves;
    test_same_dst;
    test_hazard;
    test_back_to_back;
    test_reset_mid_drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
